msk_g16mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one masked GF(16) HPC3 multiplier (`MSKg4mul_hpc3`) between two requesters. It presents operands and fresh randomness to the multiplier in the issue cycle and holds the `a` sharing for the following cycle as `ina_prev`. It captures the result into a 2-entry output buffer with valid/ready backpressure. Non-issuing cycles drive all-zero operands so no stale shares reach the gadget.

---
 rtl/msk_g16mul_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/msk_g16mul_arbiter.sv
// ============================================================================
// msk_g16mul_arbiter
//   Round-robin sharing of one masked GF(16) HPC3 multiplier between two
//   requesters, with a 2-entry result buffer under valid/ready backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module msk_g16mul_arbiter #(
  parameter int d  = 2,
  parameter int RW = 4*d*(d-1)
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4*d-1:0]  req0_a,
  input  logic [4*d-1:0]  req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4*d-1:0]  req1_a,
  input  logic [4*d-1:0]  req1_b,

  input  logic [RW-1:0]   rnd_in,
  input  logic            rnd_valid,
  output logic            rnd_ready,

  output logic [4*d-1:0]  mul_ina,
  output logic [4*d-1:0]  mul_inb,
  output logic [RW-1:0]   mul_rnd,
  output logic [4*d-1:0]  mul_ina_prev,
  input  logic [4*d-1:0]  mul_out,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*d-1:0]  out_data,
  output logic            out_id
);

  localparam int c_SW = 4*d;

  // Arbitration / pipeline state
  logic            r_rr;
  logic            r_inflight;
  logic            r_inflight_id;
  logic [c_SW-1:0] r_ina_prev;

  // Output buffer state
  logic [1:0]      r_occ;
  logic            r_head;
  logic            r_tail;
  logic [c_SW-1:0] r_buf_data [2];
  logic            r_buf_id   [2];

  logic            w_any_req;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_pending;
  logic            w_issue;
  logic            w_gnt;
  logic [c_SW-1:0] w_gnt_a;
  logic [c_SW-1:0] w_gnt_b;
  logic [1:0]      w_wr_en;

  assign w_any_req = req0_valid | req1_valid;
  assign out_valid = (r_occ != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight;

  // Slots still claimed after this cycle: buffered + in flight - leaving now.
  // A pop can only happen with r_occ >= 1, so this never underflows.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Gating with rst_n keeps every combinational output quiet during reset.
  assign w_issue = rst_n & w_any_req & rnd_valid & (w_pending < 3'd2);

  // 1 selects requester 1; rr only matters when both are asking.
  assign w_gnt   = req1_valid & (~req0_valid | r_rr);
  assign w_gnt_a = w_gnt ? req1_a : req0_a;
  assign w_gnt_b = w_gnt ? req1_b : req0_b;

  assign req0_ready = w_issue & ~w_gnt;
  assign req1_ready = w_issue &  w_gnt;
  assign rnd_ready  = w_issue;

  // Idle cycles present all-zero shares so nothing stale reaches the gadget.
  assign mul_ina      = w_issue ? w_gnt_a : '0;
  assign mul_inb      = w_issue ? w_gnt_b : '0;
  assign mul_rnd      = w_issue ? rnd_in  : '0;
  assign mul_ina_prev = r_ina_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr          <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_id <= 1'b0;
      r_ina_prev    <= '0;
    end else begin
      r_inflight <= w_issue;
      r_ina_prev <= mul_ina;
      if (w_issue) begin
        r_inflight_id <= w_gnt;
        r_rr          <= ~w_gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_entry
    assign w_wr_en[i] = w_push & (r_tail == 1'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_buf_data[i] <= '0;
        r_buf_id[i]   <= 1'b0;
      end else if (w_wr_en[i]) begin
        r_buf_data[i] <= mul_out;
        r_buf_id[i]   <= r_inflight_id;
      end
    end
  end

  assign out_data = r_buf_data[r_head];
  assign out_id   = r_buf_id[r_head];

  // The issue condition reserves a slot for every in-flight result.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(w_push && (r_occ == 2'd2) && !w_pop));

endmodule

`default_nettype wire
